// File: rtl/execute_stage.sv
// execute_stage: ALU execute stage sitting behind the decode pipeline register.
// Single-cycle logic/add/sub/shift ops plus an optional iterative shift-add
// multiply that stalls upstream while it runs.
//
// Build option:
//   EXEC_MUL_EN  defined   -> opcode 8 runs the WIDTH-cycle shift-add multiply
//                undefined -> no multiplier hardware; opcode 8 is illegal
//
// Handshake (both sides strict valid/ready):
//   An input op transfers on a rising edge where in_valid && in_ready.
//   A result transfers on a rising edge where out_valid && out_ready.
//   in_valid/rdA/rdB/op are ignored while in_ready is low. While
//   out_valid && !out_ready the result and flags are held stable, and
//   in_ready stays low so the pending result cannot be overwritten.
//   in_ready is combinational: IDLE and (no result pending or it leaves
//   this cycle), and forced low during reset.
module execute_stage #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rdA,
  input  logic [WIDTH-1:0] rdB,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             illegal,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_PASSA = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
  } state_t;

  state_t state;

  logic accept;
  logic take;
  logic is_mul;
  logic mul_done;

  // single-cycle datapath results
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_ill;
  logic [SHW-1:0]   sh;
  logic [SHW-1:0]   shl_idx;
  logic [SHW-1:0]   shr_idx;

  // next values for the registered result
  logic             load_res;
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_c;
  logic             nxt_ill;

  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign in_ready  = rst && (state == S_IDLE) && (!out_valid || out_ready);
  assign state_dbg = state;

  // SHL's last shifted-out bit is A[WIDTH-sh]; SHR's is A[sh-1]. Both are
  // only meaningful for sh != 0, so the wrapped index at sh == 0 is masked.
  assign sh      = rdB[SHW-1:0];
  assign shl_idx = SHW'(WIDTH - int'(sh));
  assign shr_idx = sh - SHW'(1);

  // Decode and evaluate the single-cycle ops
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_ill = 1'b0;
    case (op)
      OP_ADD:   {sc_c, sc_res} = {1'b0, rdA} + {1'b0, rdB};
      OP_SUB: begin
        sc_res = rdA - rdB;
        sc_c   = (rdA < rdB);
      end
      OP_AND:   sc_res = rdA & rdB;
      OP_OR:    sc_res = rdA | rdB;
      OP_XOR:   sc_res = rdA ^ rdB;
      OP_SHL: begin
        sc_res = rdA << sh;
        sc_c   = (sh != '0) ? rdA[shl_idx] : 1'b0;
      end
      OP_SHR: begin
        sc_res = rdA >> sh;
        sc_c   = (sh != '0) ? rdA[shr_idx] : 1'b0;
      end
      OP_PASSA: sc_res = rdA;
`ifdef EXEC_MUL_EN
      OP_MUL:   ;
`endif
      default:  sc_ill = 1'b1;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

  state_t              state_next;
  logic [2*WIDTH-1:0]  mcand;
  logic [2*WIDTH-1:0]  acc;
  logic [2*WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]    mplier;
  logic [SHW:0]        cnt;
  logic                busy_q;

  assign is_mul   = (op == OP_MUL);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_done = (state == S_MUL) && (cnt == CNT_LAST);
  assign busy     = busy_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // FSM next state: enter MUL on an accepted multiply, leave after WIDTH steps
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_next = S_MUL;
      S_MUL:   if (cnt == CNT_LAST)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Shift-add multiply datapath: one multiplier bit per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, rdA};
      mplier <= rdB;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (state == S_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + (SHW+1)'(1);
      if (cnt == CNT_LAST) busy_q <= 1'b0;
    end
  end
`else
  assign state    = S_IDLE;
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign busy     = 1'b0;
`endif

  // Select what gets loaded into the result register this cycle
  always_comb begin
    load_res = 1'b0;
    nxt_res  = sc_res;
    nxt_c    = sc_c;
    nxt_ill  = sc_ill;
    if (accept && !is_mul) begin
      load_res = 1'b1;
    end
`ifdef EXEC_MUL_EN
    if (mul_done) begin
      load_res = 1'b1;
      nxt_res  = acc_next[WIDTH-1:0];
      nxt_c    = |acc_next[2*WIDTH-1:WIDTH];
      nxt_ill  = 1'b0;
    end
`endif
  end

  // Result/flag register and out_valid: load on completion, clear on hand-off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out   <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_res) begin
      alu_out   <= nxt_res;
      flag_z    <= (nxt_res == '0);
      flag_c    <= nxt_c;
      flag_n    <= nxt_res[WIDTH-1];
      illegal   <= nxt_ill;
      out_valid <= 1'b1;
    end else if (take) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed + random bench for execute_stage with a
// result scoreboard. Multiply checks follow the EXEC_MUL_EN build option.
module tb_execute_stage;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] rdA = '0;
  logic [7:0] rdB = '0;
  logic [3:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] alu_out;
  logic       flag_z, flag_c, flag_n, illegal, busy;
  logic [1:0] state_dbg;

  execute_stage #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rdA(rdA), .rdB(rdB), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .illegal(illegal), .busy(busy), .state_dbg(state_dbg)
  );

  // observed result word: {illegal, N, C, Z, R}
  logic [11:0] obs;
  assign obs = {illegal, flag_n, flag_c, flag_z, alu_out};

  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  // reference model of one operation
  function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] t;
    logic [7:0]  r;
    logic        c;
    logic        ill;
    int          s;
    r = '0; c = 1'b0; ill = 1'b0; s = int'(b[2:0]);
    case (o)
      4'd0: begin t = 16'(a) + 16'(b); r = t[7:0]; c = (t > 16'd255); end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin t = 16'(a) << s; r = t[7:0]; c = t[8]; end
      4'd6: begin r = a >> s; c = (s != 0) ? a[s-1] : 1'b0; end
      4'd7: r = a;
      4'd8: begin
        if (MUL_EN) begin
          t = 16'(a) * 16'(b); r = t[7:0]; c = (t[15:8] != 8'd0);
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    return {ill, r[7], c, (r == 8'd0), r};
  endfunction

  // scoreboard: compare every result that leaves the stage
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_result got=%0h exp=none", obs);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 32'(obs), 32'(mon_exp));
      end
    end
  end

  // driver: called at posedge+1; holds the op until accepted, leaves in_valid
  // low right after the accepting edge so a following call issues back-to-back
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input bit push, input logic [11:0] e);
    int  n;
    bit  done;
    n = 0; done = 1'b0;
    in_valid = 1'b1; op = o; rdA = a; rdB = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) exp_q.push_back(e);
        done = 1'b1;
      end else begin
        n++;
        if (n > 50) begin
          checks++;
          errors++;
          $error("FAIL accept_timeout got=0 exp=1");
          done = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_m(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    issue(o, a, b, 1'b1, model(o, a, b));
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset with garbage on the inputs
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      op = 4'($urandom_range(0, 15)); rdA = 8'($urandom); rdB = 8'($urandom);
    end
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_word", 32'(obs), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // first op: latency 1
    issue(4'd0, 8'hF0, 8'h20, 1'b1, {1'b0, 1'b0, 1'b1, 1'b0, 8'h10});
    @(negedge clk);
    check("add_latency", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // back-to-back directed stream
    issue(4'd1, 8'h05, 8'h05, 1'b1, {1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
    issue(4'd1, 8'h03, 8'h05, 1'b1, {1'b0, 1'b1, 1'b1, 1'b0, 8'hFE});
    issue(4'd5, 8'h81, 8'h01, 1'b1, {1'b0, 1'b0, 1'b1, 1'b0, 8'h02});
    issue(4'd6, 8'h01, 8'h01, 1'b1, {1'b0, 1'b0, 1'b1, 1'b1, 8'h00});
    issue(4'd5, 8'h81, 8'h00, 1'b1, {1'b0, 1'b1, 1'b0, 1'b0, 8'h81});
    issue(4'd12, 8'h5A, 8'hA5, 1'b1, {1'b1, 1'b0, 1'b0, 1'b1, 8'h00});
    issue_m(4'd2, 8'hC3, 8'h0F);
    issue_m(4'd3, 8'h80, 8'h01);
    issue_m(4'd7, 8'h9D, 8'h00);
    issue_m(4'd6, 8'hB4, 8'h03);
    issue_m(4'd15, 8'h11, 8'h22);
    repeat (2) @(posedge clk);
    #1;

    // backpressure: result must hold until taken
    out_ready = 1'b0;
    issue(4'd0, 8'h01, 8'h02, 1'b1, {1'b0, 1'b0, 1'b0, 1'b0, 8'h03});
    repeat (3) begin
      @(negedge clk);
      check("hold_alu_out", 32'(alu_out), 32'h03);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(4'd4, 8'hAA, 8'h55, 1'b1, {1'b0, 1'b1, 1'b0, 1'b0, 8'hFF});
    repeat (2) @(posedge clk);
    #1;

`ifdef EXEC_MUL_EN
    // multiply timing and results
    issue(4'd8, 8'h0C, 8'h0B, 1'b1, {1'b0, 1'b1, 1'b0, 1'b0, 8'h84});
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_in_ready", 32'(in_ready), 32'd0);
      check("mul_out_valid_early", 32'(out_valid), 32'd0);
      if (i == 1) check("mul_state", 32'(state_dbg), 32'd1);
    end
    @(negedge clk);
    check("mul_out_valid", 32'(out_valid), 32'd1);
    check("mul_busy_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    issue(4'd8, 8'hFF, 8'hFF, 1'b1, {1'b0, 1'b0, 1'b1, 1'b0, 8'h01});
    repeat (10) @(posedge clk);
    #1;

    // reset in the middle of a multiply
    issue(4'd8, 8'h07, 8'h09, 1'b0, 12'h000);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_word", 32'(obs), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_output", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
`else
    // opcode 8 without the multiplier is a one-cycle illegal op
    issue(4'd8, 8'h12, 8'h34, 1'b1, {1'b1, 1'b0, 1'b0, 1'b1, 8'h00});
    @(negedge clk);
    check("mul_off_valid", 32'(out_valid), 32'd1);
    check("mul_off_illegal", 32'(illegal), 32'd1);
    check("mul_off_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
`endif

    // random ops with random downstream stalls
    for (int k = 0; k < 24; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      issue_m(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end

    // drain
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
